// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns ASCII lines from a UART RX FIFO into register bus
// accesses and writes ASCII replies into the TX FIFO.
//   "Raa\r"   -> reg_re at aa, reply "dd\r\n"
//   "Waadd\r" -> reg_we at aa with dd, reply "OK\r\n"
//   malformed -> reply "ER\r\n"
// Optional build macro UART_CMD_PARSER_ECHO_EN echoes every consumed byte
// into the TX FIFO in the cycle it is popped (pops then wait for tx_busy low).
module uart_cmd_parser #(
   parameter int MAX_LINE       = 8,
   parameter int TIMEOUT_CYCLES = 27000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_fifo_empty,
   input  logic [7:0] rx_fifo_data_out,
   output logic       rx_fifo_read_en,
   output logic [7:0] tx_fifo_data_in,
   output logic       tx_fifo_write_en,
   input  logic       tx_busy,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, COLLECT, EXEC, RD_WAIT, RESP} state_t;

   // Line length saturates one past the limit; that is enough to flag overflow.
   localparam int               LEN_W   = $clog2(MAX_LINE + 2);
   localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LINE + 1);
   localparam logic [LEN_W-1:0] LEN_LIM = LEN_W'(MAX_LINE);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t            state, state_next;
   logic [15:0]       nib;
   logic [3:0]        nib_cnt;
   logic [LEN_W-1:0]  len;
   logic              err;
   logic              is_w;
   logic              gap;
   logic [31:0]       idle_cnt;
   logic [3:0][7:0]   resp;
   logic [1:0]        resp_idx;
   logic [7:0]        addr_q;
   logic [7:0]        wdata_q;

   logic              take;
   logic              term;
   logic              send;
   logic              timed_out;
   logic              exec_wr;
   logic              exec_rd;
   logic              last_byte;
   logic [7:0]        ch;

   function automatic logic is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] c);
      logic [7:0] v;
      if (c <= 8'h39)      v = c - 8'h30;
      else if (c <= 8'h46) v = c - 8'h37;
      else                 v = c - 8'h57;
      return v[3:0];
   endfunction

   function automatic logic [7:0] hex_chr(input logic [3:0] v);
      return (v < 4'd10) ? {4'h3, v} : (8'h37 + {4'h0, v});
   endfunction

   assign ch        = rx_fifo_data_out;
   assign term      = (ch == 8'h0D) || (ch == 8'h0A);
   assign exec_wr   = is_w && (nib_cnt == 4'd4) && !err;
   assign exec_rd   = !is_w && (nib_cnt == 4'd2) && !err;
   assign send      = !reset && (state == RESP) && !tx_busy;
   assign last_byte = send && (resp_idx == 2'd3);
   assign timed_out = (TIMEOUT_CYCLES != 0) && (state == COLLECT) && !take &&
                      (idle_cnt == TMO_LAST);

   // A pop needs a byte, a collecting state and the spacer cycle after the previous pop.
`ifdef UART_CMD_PARSER_ECHO_EN
   assign take = !reset && ((state == IDLE) || (state == COLLECT)) &&
                 !rx_fifo_empty && !gap && !tx_busy;
`else
   assign take = !reset && ((state == IDLE) || (state == COLLECT)) &&
                 !rx_fifo_empty && !gap;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, COLLECT: begin
            if (take) begin
               if (term) state_next = (len == '0) ? IDLE : EXEC;
               else      state_next = COLLECT;
            end else if (timed_out) begin
               state_next = IDLE;
            end
         end
         EXEC:    state_next = exec_rd ? RD_WAIT : RESP;
         RD_WAIT: state_next = RESP;
         RESP:    if (last_byte) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode; everything is forced low while reset is high.
   always_comb begin
      rx_fifo_read_en  = take;
      tx_fifo_write_en = 1'b0;
      tx_fifo_data_in  = 8'h00;
      reg_we           = 1'b0;
      reg_re           = 1'b0;
      reg_addr         = addr_q;
      reg_wdata        = wdata_q;
      busy             = 1'b0;
      if (reset) begin
         reg_addr  = 8'h00;
         reg_wdata = 8'h00;
      end else begin
         busy = (state == EXEC) || (state == RD_WAIT) || (state == RESP);
         if (state == EXEC && exec_wr) begin
            reg_we    = 1'b1;
            reg_addr  = nib[15:8];
            reg_wdata = nib[7:0];
         end
         if (state == EXEC && exec_rd) begin
            reg_re   = 1'b1;
            reg_addr = nib[7:0];
         end
         if (send) begin
            tx_fifo_write_en = 1'b1;
            tx_fifo_data_in  = resp[resp_idx];
         end
`ifdef UART_CMD_PARSER_ECHO_EN
         if (take) begin
            tx_fifo_write_en = 1'b1;
            tx_fifo_data_in  = ch;
         end
`endif
      end
   end

   // Line parsing, timeout, bus hold registers and reply queue.
   always_ff @(posedge clock) begin
      if (reset) begin
         nib      <= '0;
         nib_cnt  <= '0;
         len      <= '0;
         err      <= 1'b0;
         is_w     <= 1'b0;
         gap      <= 1'b0;
         idle_cnt <= '0;
         resp     <= '0;
         resp_idx <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         gap <= take;

         if (state == COLLECT && !take) idle_cnt <= idle_cnt + 32'd1;
         else                           idle_cnt <= '0;

         if (take && !term) begin
            if (len != LEN_SAT) len <= len + LEN_ONE;
            if (len == '0) begin
               if (ch == "R" || ch == "r")      is_w <= 1'b0;
               else if (ch == "W" || ch == "w") is_w <= 1'b1;
               else                             err  <= 1'b1;
            end else if (len >= LEN_LIM || !is_hex(ch)) begin
               err <= 1'b1;
            end else if (!err) begin
               nib <= {nib[11:0], hex_val(ch)};
               if (nib_cnt != 4'd15) nib_cnt <= nib_cnt + 4'd1;
            end
         end

         if (state == EXEC) begin
            resp_idx <= '0;
            if (exec_wr) begin
               addr_q  <= nib[15:8];
               wdata_q <= nib[7:0];
               resp    <= {8'h0A, 8'h0D, "K", "O"};
            end else if (exec_rd) begin
               addr_q  <= nib[7:0];
            end else begin
               resp    <= {8'h0A, 8'h0D, "R", "E"};
            end
         end

         if (state == RD_WAIT)
            resp <= {8'h0A, 8'h0D, hex_chr(reg_rdata[3:0]), hex_chr(reg_rdata[7:4])};

         if (send) resp_idx <= resp_idx + 2'd1;

         if (timed_out || last_byte) begin
            nib     <= '0;
            nib_cnt <= '0;
            len     <= '0;
            err     <= 1'b0;
            is_w    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed protocol cases followed by random lines,
// compared against a line-level reference model of the command protocol.
module tb_uart_cmd_parser;

   localparam int MAX_LINE = 8;
   localparam int TMO      = 100;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx_fifo_empty;
   logic [7:0] rx_fifo_data_out;
   logic       rx_fifo_read_en;
   logic [7:0] tx_fifo_data_in;
   logic       tx_fifo_write_en;
   logic       tx_busy = 1'b0;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       busy;

   always #5 clock = ~clock;

   uart_cmd_parser #(.MAX_LINE(MAX_LINE), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset),
      .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data_out(rx_fifo_data_out),
      .rx_fifo_read_en(rx_fifo_read_en),
      .tx_fifo_data_in(tx_fifo_data_in), .tx_fifo_write_en(tx_fifo_write_en),
      .tx_busy(tx_busy),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   // First-word-fall-through RX FIFO
   logic [7:0] rx_buf [4096];
   int rd_ptr = 0;
   int wr_ptr = 0;
   assign rx_fifo_empty    = (rd_ptr == wr_ptr);
   assign rx_fifo_data_out = rx_buf[rd_ptr % 4096];
   always @(posedge clock) if (rx_fifo_read_en) rd_ptr <= rd_ptr + 1;

   // Register bus: read data is valid only in the cycle after reg_re
   logic       rd_pending = 1'b0;
   logic [7:0] rd_val = 8'h00;
   always @(posedge clock) rd_pending <= reg_re;
   assign reg_rdata = rd_pending ? rd_val : (rd_val ^ 8'hA5);

   // TX backpressure source
   bit busy_force = 1'b0;
   bit busy_rand  = 1'b0;
   always begin
      @(posedge clock);
      #2;
      tx_busy = busy_force | (busy_rand && ($urandom_range(0, 2) == 0));
   end

   // Observed traffic
   logic [7:0]  tx_got[$];
   logic [31:0] ev_got[$];
   always @(negedge clock) begin
      if (tx_fifo_write_en) tx_got.push_back(tx_fifo_data_in);
      if (reg_we) ev_got.push_back({8'h57, reg_addr, reg_wdata});
      if (reg_re) ev_got.push_back({8'h52, reg_addr, 8'h00});
   end

   // Expected traffic
   logic [7:0]  exp_tx[$];
   logic [31:0] exp_ev[$];
   logic [7:0]  last_addr  = 8'h00;
   logic [7:0]  last_wdata = 8'h00;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic bit is_hex(input logic [7:0] c);
      return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] c);
      if (c >= "0" && c <= "9") return 4'(c - "0");
      if (c >= "A" && c <= "F") return 4'(c - "A" + 10);
      return 4'(c - "a" + 10);
   endfunction

   function automatic void push_exp(input string s);
      for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
   endfunction

   function automatic void model_echo(input string s);
`ifdef UART_CMD_PARSER_ECHO_EN
      push_exp(s);
`else
      if (s.len() < 0) push_exp(s);
`endif
   endfunction

   // Protocol reference: one terminated line in, expected replies and bus ops out
   function automatic void model_line(input string body, input string term);
      int          n = body.len();
      bit          all_hex = 1'b1;
      bit          ok_r, ok_w;
      logic [7:0]  b0;
      logic [15:0] v = 16'h0;
      string       hs = "0123456789ABCDEF";
      model_echo({body, term.substr(0, 0)});
      if (n > 0) begin
         b0 = body[0];
         for (int i = 1; i < n; i++) begin
            if (!is_hex(body[i])) all_hex = 1'b0;
            else v = {v[11:0], hex_val(body[i])};
         end
         ok_r = (b0 == "R" || b0 == "r") && n == 3 && n <= MAX_LINE && all_hex;
         ok_w = (b0 == "W" || b0 == "w") && n == 5 && n <= MAX_LINE && all_hex;
         if (ok_w) begin
            exp_ev.push_back({8'h57, v[15:8], v[7:0]});
            last_addr  = v[15:8];
            last_wdata = v[7:0];
            push_exp("OK\r\n");
         end else if (ok_r) begin
            exp_ev.push_back({8'h52, v[7:0], 8'h00});
            last_addr = v[7:0];
            exp_tx.push_back(hs[rd_val[7:4]]);
            exp_tx.push_back(hs[rd_val[3:0]]);
            push_exp("\r\n");
         end else begin
            push_exp("ER\r\n");
         end
      end
      if (term.len() > 1) model_echo(term.substr(1, 1));
   endfunction

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         rx_buf[wr_ptr % 4096] = s[i];
         wr_ptr++;
      end
   endtask

   task automatic settle();
      int quiet = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (rx_fifo_empty && !busy) quiet++;
         else quiet = 0;
         if (quiet >= 6) return;
      end
      check("settle_timeout", 32'd0, 32'd1);
   endtask

   task automatic compare(input string tag);
      int n;
      check({tag, " tx_count"}, tx_got.size(), exp_tx.size());
      n = (tx_got.size() < exp_tx.size()) ? tx_got.size() : exp_tx.size();
      for (int i = 0; i < n; i++) check({tag, " tx_byte"}, tx_got[i], exp_tx[i]);
      check({tag, " bus_ops"}, ev_got.size(), exp_ev.size());
      n = (ev_got.size() < exp_ev.size()) ? ev_got.size() : exp_ev.size();
      for (int i = 0; i < n; i++) check({tag, " bus_op"}, ev_got[i], exp_ev[i]);
      check({tag, " addr_hold"}, reg_addr, last_addr);
      check({tag, " wdata_hold"}, reg_wdata, last_wdata);
      tx_got.delete();
      exp_tx.delete();
      ev_got.delete();
      exp_ev.delete();
   endtask

   task automatic run_line(input string tag, input string body, input string term,
                           input logic [7:0] rv);
      rd_val = rv;
      model_line(body, term);
      push_str({body, term});
      settle();
      compare(tag);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " read_en"}, rx_fifo_read_en, 0);
      check({tag, " write_en"}, tx_fifo_write_en, 0);
      check({tag, " tx_data"}, tx_fifo_data_in, 0);
      check({tag, " reg_we"}, reg_we, 0);
      check({tag, " reg_re"}, reg_re, 0);
      check({tag, " reg_addr"}, reg_addr, 0);
      check({tag, " reg_wdata"}, reg_wdata, 0);
      check({tag, " busy"}, busy, 0);
   endtask

   function automatic string pick(input string s);
      int k = $urandom_range(0, s.len() - 1);
      return s.substr(k, k);
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      string body, term;
      string hexset = "0123456789abcdefABCDEF";
      string junk   = "RrWwX0123456789aAbBcCdDeEfFgG z";
      int    target;

      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      check_idle_outputs("reset");

      run_line("write", "W1A5C", "\r", 8'h00);
      run_line("read", "r1a", "\n", 8'hE7);
      run_line("bad_hex", "W1G00", "\r", 8'h11);
      run_line("bad_len_r", "R123", "\r", 8'h22);
      run_line("bad_cmd", "X", "\r", 8'h33);
      run_line("empty_crlf", "", "\r\n", 8'h44);
      run_line("crlf_write", "w0fF0", "\r\n", 8'h55);
      run_line("line_max", "W1A5C000", "\r", 8'h66);
      run_line("line_over", "R1A345678", "\n", 8'h77);

      // Backpressure held for 10 cycles across a read reply
      rd_val = 8'h3C;
      model_line("R5B", "\r");
      push_str("R5B\r");
      for (int c = 0; c < 200 && !busy; c++) tick();
      check("hold busy_seen", busy, 1);
      busy_force = 1'b1;
      target = tx_got.size();
      repeat (10) tick();
      check("hold no_writes", tx_got.size(), target);
      busy_force = 1'b0;
      settle();
      compare("hold");

      // Partial line left idle past the timeout is dropped silently
      model_echo("W12");
      push_str("W12");
      repeat (TMO + 50) tick();
      check("timeout no_reply", tx_got.size(), exp_tx.size());
      check("timeout busy", busy, 0);
      run_line("after_timeout", "R12", "\r", 8'hC9);

      // Reset after two reply bytes have gone out
      model_line("W1A5C", "\r");
      void'(exp_tx.pop_back());
      void'(exp_tx.pop_back());
      target = exp_tx.size();
      push_str("W1A5C\r");
      for (int c = 0; c < 500; c++) begin
         @(posedge clock);
         if (tx_got.size() >= target) break;
      end
      check("mid_resp progress", tx_got.size(), target);
      #1 reset = 1'b1;
      tick();
      reset = 1'b0;
      last_addr  = 8'h00;
      last_wdata = 8'h00;
      check_idle_outputs("mid_resp");
      settle();
      compare("mid_resp");
      run_line("after_reset", "R7e", "\r", 8'h0B);

      // Random lines under random backpressure
      busy_rand = 1'b1;
      for (int it = 0; it < 40; it++) begin
         body = "";
         case ($urandom_range(0, 3))
            0: begin
               body = pick("Rr");
               repeat (2) body = {body, pick(hexset)};
            end
            1: begin
               body = pick("Ww");
               repeat (4) body = {body, pick(hexset)};
            end
            default: begin
               repeat ($urandom_range(0, 11)) body = {body, pick(junk)};
            end
         endcase
         case ($urandom_range(0, 2))
            0:       term = "\r";
            1:       term = "\n";
            default: term = "\r\n";
         endcase
         run_line("random", body, term, 8'($urandom));
      end
      busy_rand = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
